// File: rtl/decode_stage_if.sv
// Fetch-side, execute-side and retire-side signals of the RV32I decode stage.
// The stage itself uses the slave modport; whatever drives it uses master.
interface decode_stage_if #(
    parameter int ALUOP_W = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_inst;
    logic [31:0]        in_pc;
    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [31:0]        out_pc;
    logic [4:0]         out_ra1;
    logic [4:0]         out_ra2;
    logic [4:0]         out_wa;
    logic [31:0]        out_imm;
    logic [ALUOP_W-1:0] out_aluop;
    logic               out_re1;
    logic               out_re2;
    logic               out_we;
    logic               out_pce;
    logic               out_imme;
    logic               out_jmpe;
    logic               out_be;
    logic [2:0]         out_bop;
    logic               out_mre;
    logic               out_mwe;
    logic [2:0]         out_msize;
    logic               out_illegal;

    logic               wb_valid;
    logic [4:0]         wb_wa;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready, wb_valid, wb_wa,
        input  in_ready, out_valid, out_pc, out_ra1, out_ra2, out_wa, out_imm,
               out_aluop, out_re1, out_re2, out_we, out_pce, out_imme, out_jmpe,
               out_be, out_bop, out_mre, out_mwe, out_msize, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready, wb_valid, wb_wa,
        output in_ready, out_valid, out_pc, out_ra1, out_ra2, out_wa, out_imm,
               out_aluop, out_re1, out_re2, out_we, out_pce, out_imme, out_jmpe,
               out_be, out_bop, out_mre, out_mwe, out_msize, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a register scoreboard that stalls issue
// on RAW/WAW hazards and when too many register writes are still in flight.
module decode_stage #(
    parameter int SB_DEPTH = 4,
    parameter int ALUOP_W  = 8
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_e;

    function automatic alu_e alu_sel(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    logic [4:0]  d_ra1, d_ra2, d_wa;
    logic [31:0] d_imm;
    alu_e        d_alu;
    logic        d_re1, d_re2, d_we, d_pce, d_imme, d_jmpe, d_be, d_mre, d_mwe, d_illegal;
    logic [2:0]  d_bop, d_msize;

    // Register addresses are only driven for operands the instruction uses;
    // an illegal instruction leaves every field at zero.
    always_comb begin
        d_ra1 = '0; d_ra2 = '0; d_wa = '0; d_imm = '0; d_alu = ALU_NOP;
        d_re1 = 1'b0; d_re2 = 1'b0; d_we = 1'b0; d_pce = 1'b0; d_imme = 1'b0;
        d_jmpe = 1'b0; d_be = 1'b0; d_bop = '0; d_mre = 1'b0; d_mwe = 1'b0;
        d_msize = '0; d_illegal = 1'b0;
        case (opcode)
            OP_R: begin
                if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
                    d_ra1 = rs1; d_ra2 = rs2; d_wa = rd;
                    d_re1 = 1'b1; d_re2 = 1'b1; d_we = 1'b1;
                    d_alu = alu_sel(f3, f7[5]);
                end else begin
                    d_illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if ((f3 == 3'b001 && f7 != 7'b0000000) ||
                    (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)) begin
                    d_illegal = 1'b1;
                end else begin
                    d_ra1 = rs1; d_wa = rd;
                    d_re1 = 1'b1; d_we = 1'b1; d_imme = 1'b1;
                    d_alu = alu_sel(f3, f3 == 3'b101 && f7[5]);
                    d_imm = (f3[1:0] == 2'b01) ? {27'b0, inst[24:20]} : imm_i;
                end
            end
            OP_JAL: begin
                d_wa = rd; d_we = 1'b1; d_jmpe = 1'b1;
                d_pce = 1'b1; d_imme = 1'b1; d_alu = ALU_ADD; d_imm = imm_j;
            end
            OP_JALR: begin
                d_ra1 = rs1; d_re1 = 1'b1; d_wa = rd; d_we = 1'b1; d_jmpe = 1'b1;
                d_imme = 1'b1; d_alu = ALU_ADD; d_imm = imm_i;
            end
            OP_LUI: begin
                // x0 + imm: reading x0 never stalls
                d_re1 = 1'b1; d_wa = rd; d_we = 1'b1;
                d_imme = 1'b1; d_alu = ALU_ADD; d_imm = imm_u;
            end
            OP_AUIPC: begin
                d_pce = 1'b1; d_imme = 1'b1; d_wa = rd; d_we = 1'b1;
                d_alu = ALU_ADD; d_imm = imm_u;
            end
            OP_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    d_illegal = 1'b1;
                end else begin
                    d_ra1 = rs1; d_ra2 = rs2; d_re1 = 1'b1; d_re2 = 1'b1;
                    d_be = 1'b1; d_bop = f3; d_pce = 1'b1; d_imme = 1'b1;
                    d_alu = ALU_ADD; d_imm = imm_b;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b011 || f3[2:1] == 2'b11) begin
                    d_illegal = 1'b1;
                end else begin
                    d_ra1 = rs1; d_re1 = 1'b1; d_wa = rd; d_we = 1'b1;
                    d_imme = 1'b1; d_alu = ALU_ADD; d_mre = 1'b1; d_msize = f3;
                    d_imm = imm_i;
                end
            end
            OP_STORE: begin
                if (f3 > 3'b010) begin
                    d_illegal = 1'b1;
                end else begin
                    d_ra1 = rs1; d_ra2 = rs2; d_re1 = 1'b1; d_re2 = 1'b1;
                    d_imme = 1'b1; d_alu = ALU_ADD; d_mwe = 1'b1; d_msize = f3;
                    d_imm = imm_s;
                end
            end
            default: d_illegal = 1'b1;
        endcase
    end

    logic [31:1] pending_q, pending_d;
    logic [31:0] busy_vec;
    logic        out_writes, stall, in_fire, sb_set;
    int          in_flight;

    // A register is busy while pending or while its writer sits in the output register.
    assign out_writes = bus.out_valid && bus.out_we && bus.out_wa != 5'd0;
    always_comb begin
        busy_vec = {pending_q, 1'b0};
        if (out_writes) busy_vec[bus.out_wa] = 1'b1;
    end

    assign in_flight = $countones(pending_q) + (out_writes ? 1 : 0);
    assign stall = (d_re1 && busy_vec[d_ra1]) || (d_re2 && busy_vec[d_ra2]) ||
                   (d_we && busy_vec[d_wa]) ||
                   (d_we && d_wa != 5'd0 && in_flight >= SB_DEPTH);

    assign bus.in_ready = !rst && !bus.flush && !stall && (!bus.out_valid || bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign sb_set       = out_writes && bus.out_ready && !bus.flush;

    // Set wins over a same-cycle retire of the same register.
    always_comb begin
        pending_d = pending_q;
        if (bus.wb_valid && bus.wb_wa != 5'd0) pending_d[bus.wb_wa] = 1'b0;
        if (sb_set) pending_d[bus.out_wa] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0; bus.out_pc <= '0; bus.out_ra1 <= '0; bus.out_ra2 <= '0;
            bus.out_wa <= '0; bus.out_imm <= '0; bus.out_aluop <= '0; bus.out_re1 <= 1'b0;
            bus.out_re2 <= 1'b0; bus.out_we <= 1'b0; bus.out_pce <= 1'b0; bus.out_imme <= 1'b0;
            bus.out_jmpe <= 1'b0; bus.out_be <= 1'b0; bus.out_bop <= '0; bus.out_mre <= 1'b0;
            bus.out_mwe <= 1'b0; bus.out_msize <= '0; bus.out_illegal <= 1'b0;
        end else begin
            if (bus.flush)          bus.out_valid <= 1'b0;
            else if (in_fire)       bus.out_valid <= 1'b1;
            else if (bus.out_ready) bus.out_valid <= 1'b0;
            if (in_fire) begin
                bus.out_pc <= bus.in_pc; bus.out_ra1 <= d_ra1; bus.out_ra2 <= d_ra2;
                bus.out_wa <= d_wa; bus.out_imm <= d_imm; bus.out_aluop <= ALUOP_W'(d_alu);
                bus.out_re1 <= d_re1; bus.out_re2 <= d_re2; bus.out_we <= d_we;
                bus.out_pce <= d_pce; bus.out_imme <= d_imme; bus.out_jmpe <= d_jmpe;
                bus.out_be <= d_be; bus.out_bop <= d_bop; bus.out_mre <= d_mre;
                bus.out_mwe <= d_mwe; bus.out_msize <= d_msize; bus.out_illegal <= d_illegal;
            end
        end
    end

    set_clear_collision: assert property (@(posedge clk) disable iff (rst)
        !(sb_set && bus.wb_valid && bus.wb_wa == bus.out_wa));
endmodule

// File: tb/tb_decode_stage.sv
// Directed and randomized bench for decode_stage (SB_DEPTH=2) checked every
// cycle against an instruction-level reference model of decode and scoreboard.
module tb_decode_stage;
    localparam int SB = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ra1, ra2, wa;
        logic [31:0] imm;
        logic [7:0]  aluop;
        logic        re1, re2, we, pce, imme, jmpe, be;
        logic [2:0]  bop;
        logic        mre, mwe;
        logic [2:0]  msize;
        logic        illegal;
    } dec_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   failed = 0;

    bit        m_valid;
    dec_t      m_reg;
    bit [31:0] m_pend;
    int        retire_q[$];
    int        alu_tbl[8] = '{1, 3, 4, 5, 6, 7, 9, 10};

    decode_stage_if #(.ALUOP_W(8)) bus ();
    decode_stage #(.SB_DEPTH(SB), .ALUOP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic dec_t ref_decode(logic [31:0] w, logic [31:0] pc);
        dec_t       d = '0;
        logic [2:0] f3 = w[14:12];
        logic [6:0] f7 = w[31:25];
        logic [12:0] boff = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [20:0] joff = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        logic [11:0] ioff = w[31:20];
        logic [11:0] soff = {w[31:25], w[11:7]};
        bit ok = 1;
        d.pc = pc;
        d.aluop = 8'd1;
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                d.aluop = 8'(alu_tbl[f3] + ((f7 == 7'h20) ? 1 : 0));
                d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.wa = w[11:7];
                d.re1 = 1; d.re2 = 1; d.we = 1;
            end
            7'h13: begin
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
                d.aluop = 8'(alu_tbl[f3] + ((f3 == 5 && f7 == 7'h20) ? 1 : 0));
                d.imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'($signed(ioff));
                d.ra1 = w[19:15]; d.wa = w[11:7]; d.re1 = 1; d.we = 1; d.imme = 1;
            end
            7'h6F: begin
                d.wa = w[11:7]; d.we = 1; d.jmpe = 1; d.pce = 1; d.imme = 1;
                d.imm = 32'($signed(joff));
            end
            7'h67: begin
                d.ra1 = w[19:15]; d.re1 = 1; d.wa = w[11:7]; d.we = 1; d.jmpe = 1;
                d.imme = 1; d.imm = 32'($signed(ioff));
            end
            7'h37: begin
                d.re1 = 1; d.wa = w[11:7]; d.we = 1; d.imme = 1; d.imm = {w[31:12], 12'h000};
            end
            7'h17: begin
                d.pce = 1; d.imme = 1; d.wa = w[11:7]; d.we = 1; d.imm = {w[31:12], 12'h000};
            end
            7'h63: begin
                ok = (f3 != 2 && f3 != 3);
                d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.re1 = 1; d.re2 = 1;
                d.be = 1; d.bop = f3; d.pce = 1; d.imme = 1; d.imm = 32'($signed(boff));
            end
            7'h03: begin
                ok = !(f3 == 3 || f3 == 6 || f3 == 7);
                d.ra1 = w[19:15]; d.re1 = 1; d.wa = w[11:7]; d.we = 1; d.imme = 1;
                d.mre = 1; d.msize = f3; d.imm = 32'($signed(ioff));
            end
            7'h23: begin
                ok = (f3 <= 2);
                d.ra1 = w[19:15]; d.ra2 = w[24:20]; d.re1 = 1; d.re2 = 1; d.imme = 1;
                d.mwe = 1; d.msize = f3; d.imm = 32'($signed(soff));
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            d = '0;
            d.pc = pc;
            d.illegal = 1;
        end
        return d;
    endfunction

    function automatic bit m_busy(logic [4:0] r);
        return r != 0 && (m_pend[r] || (m_valid && m_reg.we && m_reg.wa == r));
    endfunction

    function automatic bit m_stall(dec_t d);
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_pend[i]) n++;
        if (m_valid && m_reg.we && m_reg.wa != 0) n++;
        return (d.re1 && m_busy(d.ra1)) || (d.re2 && m_busy(d.ra2)) ||
               (d.we && m_busy(d.wa)) || (d.we && d.wa != 0 && n >= SB);
    endfunction

    function automatic dec_t dut_fields();
        return '{bus.out_pc, bus.out_ra1, bus.out_ra2, bus.out_wa, bus.out_imm, bus.out_aluop,
                 bus.out_re1, bus.out_re2, bus.out_we, bus.out_pce, bus.out_imme, bus.out_jmpe,
                 bus.out_be, bus.out_bop, bus.out_mre, bus.out_mwe, bus.out_msize, bus.out_illegal};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic ordy, input logic fl, input logic wbv, input logic [4:0] wba);
        bus.in_valid = v; bus.in_inst = inst; bus.in_pc = pc; bus.out_ready = ordy;
        bus.flush = fl; bus.wb_valid = wbv; bus.wb_wa = wba;
    endtask

    task automatic model_reset();
        m_valid = 0; m_reg = '0; m_pend = '0; retire_q.delete();
    endtask

    task automatic check_ready(input string tag, input logic exp);
        #1 checkOutput(tag, bus.in_ready, exp);
    endtask

    // Check against the model at the negedge, then advance the model across the posedge.
    task automatic cycle();
        dec_t d, n_reg;
        bit rdy, fire, ofire, n_valid;
        bit [31:0] n_pend;
        bit push;
        @(negedge clk);
        d = ref_decode(bus.in_inst, bus.in_pc);
        rdy = !rst && !bus.flush && !m_stall(d) && (!m_valid || bus.out_ready);
        checkOutput("in_ready", bus.in_ready, rdy);
        checkOutput("out_valid", bus.out_valid, m_valid);
        checkOutput("out_fields", dut_fields(), m_reg);
        fire  = bus.in_valid && rdy;
        ofire = m_valid && bus.out_ready && !bus.flush;
        n_pend = m_pend;
        if (bus.wb_valid && bus.wb_wa != 0) n_pend[bus.wb_wa] = 0;
        push = ofire && m_reg.we && m_reg.wa != 0;
        if (push) n_pend[m_reg.wa] = 1;
        n_valid = bus.flush ? 0 : fire ? 1 : ofire ? 0 : m_valid;
        n_reg = fire ? d : m_reg;
        if (bus.wb_valid && bus.wb_wa != 0) begin
            for (int i = 0; i < retire_q.size(); i++)
                if (retire_q[i] == int'(bus.wb_wa)) begin retire_q.delete(i); break; end
        end
        if (push) retire_q.push_back(int'(m_reg.wa));
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else begin m_valid = n_valid; m_reg = n_reg; m_pend = n_pend; end
    endtask

    function automatic logic [31:0] gen_inst();
        logic [6:0] ops[9] = '{7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h63, 7'h03, 7'h23};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 7));
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0, 1: w[31:25] = 7'h00;
            2:    w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        model_reset();
        cycle(); cycle();
        checkOutput("reset out_valid", bus.out_valid, 0);
        checkOutput("reset fields", dut_fields(), dec_t'('0));
        rst = 1'b0;

        // back-to-back independent
        applyStimulus(1, 32'h00500093, 32'h100, 1, 0, 0, 0); cycle();
        checkOutput("b2b valid0", bus.out_valid, 1);
        checkOutput("b2b aluop0", bus.out_aluop, 8'd1);
        checkOutput("b2b imm0", bus.out_imm, 32'd5);
        applyStimulus(1, 32'h00418133, 32'h104, 1, 0, 0, 0);
        check_ready("b2b ready1", 1); cycle();
        checkOutput("b2b aluop1", bus.out_aluop, 8'd1);
        checkOutput("b2b imm1", bus.out_imm, 32'd0);
        checkOutput("b2b pc1", bus.out_pc, 32'h104);
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        checkOutput("b2b drained", bus.out_valid, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd1); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd2); cycle();

        // RAW on x1
        applyStimulus(1, 32'h00700093, 32'h200, 1, 0, 0, 0); cycle();
        applyStimulus(1, 32'h0000A103, 32'h204, 1, 0, 0, 0);
        check_ready("raw stall outreg", 0); cycle();
        check_ready("raw stall pending", 0); cycle();
        applyStimulus(1, 32'h0000A103, 32'h204, 1, 0, 1, 5'd1);
        check_ready("raw no bypass", 0); cycle();
        applyStimulus(1, 32'h0000A103, 32'h204, 1, 0, 0, 0);
        check_ready("raw released", 1); cycle();
        checkOutput("raw mre", bus.out_mre, 1);
        checkOutput("raw msize", bus.out_msize, 3'b010);
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd2); cycle();

        // backpressure
        applyStimulus(1, 32'h40838333, 32'h300, 0, 0, 0, 0); cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00418133, 32'h304, 0, 0, 0, 0);
            check_ready("bp ready", 0);
            checkOutput("bp aluop", bus.out_aluop, 8'd2);
            checkOutput("bp pc", bus.out_pc, 32'h300);
            cycle();
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        checkOutput("bp single fire", bus.out_valid, 0);
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd6); cycle();

        // capacity with SB_DEPTH=2
        applyStimulus(1, 32'h00100093, 32'h400, 1, 0, 0, 0); cycle();
        applyStimulus(1, 32'h00200113, 32'h404, 1, 0, 0, 0);
        check_ready("cap second", 1); cycle();
        applyStimulus(1, 32'h00300193, 32'h408, 1, 0, 0, 0);
        check_ready("cap stall", 0); cycle();
        check_ready("cap stall pend", 0); cycle();
        applyStimulus(1, 32'h00952223, 32'h40C, 1, 0, 0, 0);
        check_ready("cap store", 1); cycle();
        checkOutput("store imm", bus.out_imm, 32'd4);
        checkOutput("store mwe", bus.out_mwe, 1);
        checkOutput("store we", bus.out_we, 0);
        applyStimulus(1, 32'h00300193, 32'h410, 1, 0, 1, 5'd1);
        check_ready("cap wb cycle", 0); cycle();
        applyStimulus(1, 32'h00300193, 32'h410, 1, 0, 0, 0);
        check_ready("cap after wb", 1); cycle();
        checkOutput("cap x3 wa", bus.out_wa, 5'd3);

        // illegal
        applyStimulus(1, 32'hFFFFFFFF, 32'h500, 1, 0, 0, 0);
        check_ready("illegal ready", 1); cycle();
        checkOutput("illegal flag", bus.out_illegal, 1);
        checkOutput("illegal we", bus.out_we, 0);
        checkOutput("illegal aluop", bus.out_aluop, 8'd0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd2); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd3); cycle();

        // flush
        applyStimulus(1, 32'h00400213, 32'h600, 0, 0, 0, 0); cycle();
        checkOutput("flush pre", bus.out_valid, 1);
        applyStimulus(1, 32'h000202B3, 32'h604, 0, 1, 0, 0);
        check_ready("flush blocks", 0); cycle();
        checkOutput("flush kill", bus.out_valid, 0);
        applyStimulus(1, 32'h000202B3, 32'h604, 1, 0, 0, 0);
        check_ready("flush x4 free", 1); cycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd5); cycle();

        // reset mid-stream
        applyStimulus(1, 32'h00500293, 32'h700, 1, 0, 0, 0); cycle();
        applyStimulus(1, 32'h00600313, 32'h704, 1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("mid valid", bus.out_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("mid rst valid", bus.out_valid, 0);
        checkOutput("mid rst ready", bus.in_ready, 0);
        checkOutput("mid rst wa", bus.out_wa, 5'd0);
        model_reset();
        cycle();
        rst = 1'b0;
        applyStimulus(1, 32'h000283B3, 32'h708, 1, 0, 0, 0);
        check_ready("mid x5 cleared", 1); cycle();
        applyStimulus(0, 0, 0, 1, 0, 0, 0); cycle();
        applyStimulus(0, 0, 0, 1, 0, 1, 5'd7); cycle();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic ordy, fl, wbv;
            logic [4:0] wba;
            ordy = ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 15) == 0);
            if (fl) ordy = 1'b0;
            wbv = (retire_q.size() > 0) && ($urandom_range(0, 2) == 0);
            wba = wbv ? 5'(retire_q[0]) : 5'd0;
            applyStimulus($urandom_range(0, 3) != 0, gen_inst(), $urandom & 32'hFFFF_FFFC,
                          ordy, fl, wbv, wba);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
